// File: rtl/rom_sequence_controller_pkg.sv
// -----------------------------------------------------------------------------
// rom_sequence_controller_pkg
// Shared definitions for the Simon-style round controller: the FSM state
// encoding, default timing constants and the timer-width helper.
// No ports (package).
// -----------------------------------------------------------------------------
package rom_sequence_controller_pkg;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SHOW_FETCH = 4'd1,
    SHOW_ON    = 4'd2,
    SHOW_OFF   = 4'd3,
    IN_FETCH   = 4'd4,
    IN_WAIT    = 4'd5,
    IN_RELEASE = 4'd6,
    NEXT_ROUND = 4'd7,
    WIN        = 4'd8,
    LOSE       = 4'd9
  } state_e;

  localparam int DEF_SHOW_CYCLES    = 1000;
  localparam int DEF_GAP_CYCLES     = 500;
  localparam int DEF_TIMEOUT_CYCLES = 5000;
  localparam int DEF_LAST_ROUND     = 15;

  // Width needed for one timer shared by all three intervals.
  function automatic int timer_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rom_sequence_controller_interval_timer.sv
// -----------------------------------------------------------------------------
// rom_sequence_controller_interval_timer
// Up-counter that restarts from 0 on load and flags done on the cycle where
// count == limit-1, so a state that loads it on entry lasts exactly 'limit'
// cycles. It holds at limit-1 rather than wrapping.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset
//   load   in   restart count at 0 on the next edge
//   limit  in   interval length in cycles
//   done   out  high on the last cycle of the interval
// -----------------------------------------------------------------------------
module rom_sequence_controller_interval_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] limit,
  output logic             done
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // NOTE: every signal written here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    done    = (count_q == limit - WIDTH'(1));
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (!done) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/rom_sequence_controller.sv
// -----------------------------------------------------------------------------
// rom_sequence_controller
// Runs a Simon-style memory game against an external 16x4 synchronous ROM of
// one-hot patterns. Round r plays words 0..r on the LEDs, then checks the
// player's presses against the same words. Ends in WIN after the last round,
// or LOSE on a wrong press or timeout.
// Ports:
//   clock          in   rising-edge clock
//   reset          in   synchronous active-high reset
//   start          in   one-cycle pulse, honoured in IDLE/WIN/LOSE
//   buttons[3:0]   in   debounced buttons, active-high
//   rom_data[3:0]  in   ROM output, valid one cycle after rom_address
//   rom_address    out  registered ROM address
//   leds[3:0]      out  playback pattern (SHOW_ON only)
//   round[3:0]     out  current round index
//   waiting_input  out  high in IN_WAIT
//   won / lost     out  high in WIN / LOSE
// -----------------------------------------------------------------------------
module rom_sequence_controller
  import rom_sequence_controller_pkg::*;
#(
  parameter int SHOW_CYCLES    = DEF_SHOW_CYCLES,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int LAST_ROUND     = DEF_LAST_ROUND
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] buttons,
  input  logic [3:0] rom_data,
  output logic [3:0] rom_address,
  output logic [3:0] leds,
  output logic [3:0] round,
  output logic       waiting_input,
  output logic       won,
  output logic       lost
);

  localparam int TW = timer_width(SHOW_CYCLES, GAP_CYCLES, TIMEOUT_CYCLES);

  state_e     state_q, state_d;
  logic [3:0] round_q, round_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] addr_q, addr_d;
  logic [3:0] btn_prev_q;

  logic          press;
  logic          timer_load;
  logic          timer_done;
  logic [TW-1:0] timer_limit;

  // A press is the first cycle any button goes high from all-released, so a
  // button already held on entry to IN_WAIT is not taken as a new press.
  assign press = (buttons != 4'd0) && (btn_prev_q == 4'd0);

  // Any state change restarts the timer, so each timed state counts from 0.
  assign timer_load = (state_d != state_q);

  always_comb begin
    unique case (state_q)
      SHOW_OFF: timer_limit = TW'(GAP_CYCLES);
      IN_WAIT:  timer_limit = TW'(TIMEOUT_CYCLES);
      default:  timer_limit = TW'(SHOW_CYCLES);
    endcase
  end

  rom_sequence_controller_interval_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load),
    .limit (timer_limit),
    .done  (timer_done)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE, WIN, LOSE: begin
        if (start) begin
          state_d = SHOW_FETCH;
          round_d = '0;
          idx_d   = '0;
          addr_d  = '0;
        end
      end
      SHOW_FETCH: state_d = SHOW_ON;
      SHOW_ON: if (timer_done) state_d = SHOW_OFF;
      SHOW_OFF: begin
        if (timer_done) begin
          // Comparing before incrementing keeps idx within 0..round.
          if (idx_q == round_q) begin
            idx_d   = '0;
            addr_d  = '0;
            state_d = IN_FETCH;
          end else begin
            idx_d   = idx_q + 4'd1;
            addr_d  = idx_q + 4'd1;
            state_d = SHOW_FETCH;
          end
        end
      end
      IN_FETCH: state_d = IN_WAIT;
      IN_WAIT: begin
        if (press && (buttons == rom_data)) state_d = IN_RELEASE;
        else if (press)                     state_d = LOSE;
        else if (timer_done)                state_d = LOSE;
      end
      IN_RELEASE: begin
        if (buttons == 4'd0) begin
          if (idx_q == round_q) begin
            state_d = NEXT_ROUND;
          end else begin
            idx_d   = idx_q + 4'd1;
            addr_d  = idx_q + 4'd1;
            state_d = IN_FETCH;
          end
        end
      end
      NEXT_ROUND: begin
        if (round_q == 4'(LAST_ROUND)) begin
          state_d = WIN;
        end else begin
          round_d = round_q + 4'd1;
          idx_d   = '0;
          addr_d  = '0;
          state_d = SHOW_FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      round_q    <= '0;
      idx_q      <= '0;
      addr_q     <= '0;
      btn_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      round_q    <= round_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      btn_prev_q <= buttons;
    end
  end

  assign rom_address   = addr_q;
  assign round         = round_q;
  assign leds          = (state_q == SHOW_ON) ? rom_data : 4'd0;
  assign waiting_input = (state_q == IN_WAIT);
  assign won           = (state_q == WIN);
  assign lost          = (state_q == LOSE);

endmodule

// File: tb/tb_rom_sequence_controller.sv
// -----------------------------------------------------------------------------
// tb_rom_sequence_controller
// Self-checking bench: a behavioural ROM plus an expectation model built from
// the game rules (round r shows words 0..r for SHOW cycles with GAP blanks,
// then accepts presses with a TIMEOUT window). Press delays and hold times
// are randomised.
// -----------------------------------------------------------------------------
module tb_rom_sequence_controller;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TMO  = 20;
  localparam int LAST = 15;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] buttons;
  logic [3:0] rom_data;
  logic [3:0] rom_address;
  logic [3:0] leds;
  logic [3:0] round;
  logic       waiting_input;
  logic       won;
  logic       lost;

  logic [3:0] rom [16] = '{4'h1, 4'h4, 4'h2, 4'h8, 4'h1, 4'h4, 4'h2, 4'h8,
                           4'h1, 4'h1, 4'h8, 4'h8, 4'h2, 4'h4, 4'h4, 4'h1};

  int total = 0;
  int bad   = 0;

  rom_sequence_controller #(
    .SHOW_CYCLES    (SHOW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .LAST_ROUND     (LAST)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .buttons       (buttons),
    .rom_data      (rom_data),
    .rom_address   (rom_address),
    .leds          (leds),
    .round         (round),
    .waiting_input (waiting_input),
    .won           (won),
    .lost          (lost)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: data follows the address one edge later.
  always @(posedge clock) rom_data <= rom[rom_address];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_leds"}, leds, 0);
    check({tag, "_round"}, round, 0);
    check({tag, "_addr"}, rom_address, 0);
    check({tag, "_wait"}, waiting_input, 0);
    check({tag, "_won"}, won, 0);
    check({tag, "_lost"}, lost, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entered on the SHOW_FETCH cycle of round r; leaves on the first IN_WAIT cycle.
  task automatic play_round(input int r);
    check("play_round", round, r);
    for (int s = 0; s <= r; s++) begin
      check("fetch_leds", leds, 0);
      check("fetch_addr", rom_address, s);
      step();
      for (int c = 0; c < SHOW; c++) begin
        check("show_leds", leds, rom[s]);
        step();
      end
      for (int c = 0; c < GAP; c++) begin
        check("gap_leds", leds, 0);
        check("gap_wait", waiting_input, 0);
        step();
      end
    end
    check("in_fetch_wait", waiting_input, 0);
    check("in_fetch_addr", rom_address, 0);
    step();
    check("in_wait", waiting_input, 1);
  endtask

  // Entered on the first IN_WAIT cycle of round r. Step bad_step (if >=0)
  // presses bad_val instead of the ROM word. first_dmax bounds the idle delay
  // before the first press (rest use the full window).
  task automatic answer_round(input int r, input int bad_step, input logic [3:0] bad_val,
                              input int first_dmax);
    int         d;
    logic [3:0] v;
    for (int s = 0; s <= r; s++) begin
      if (s > 0) begin
        check("ans_fetch_addr", rom_address, s);
        step();
      end
      d = $urandom_range(0, (s == 0) ? first_dmax : TMO - 1);
      v = (s == bad_step) ? bad_val : rom[s];
      for (int c = 0; c < d; c++) begin
        check("ans_waiting", waiting_input, 1);
        step();
      end
      buttons = v;
      step();
      if (v != rom[s]) begin
        check("wrong_lost", lost, 1);
        check("wrong_round", round, r);
        check("wrong_wait", waiting_input, 0);
        buttons = 4'd0;
        return;
      end
      check("rel_wait", waiting_input, 0);
      check("rel_lost", lost, 0);
      repeat ($urandom_range(0, 3)) step();
      buttons = 4'd0;
      step();
    end
    check("next_won", won, 0);
    check("next_round", round, r);
    step();
    if (r == LAST) begin
      check("win_won", won, 1);
      check("win_round", round, LAST);
    end else begin
      check("adv_round", round, r + 1);
      check("adv_won", won, 0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    buttons = 4'd0;
    step();
    step();
    check_all_zero("reset");
    reset = 1'b0;
    step();
    check_all_zero("idle");

    // Full game: 16 rounds, 136 correct presses, ending in WIN.
    pulse_start();
    for (int r = 0; r <= LAST; r++) begin
      play_round(r);
      answer_round(r, -1, 4'd0, TMO - 1);
    end
    repeat (3) step();
    check("win_hold", won, 1);
    check("win_hold_round", round, LAST);
    check("win_hold_leds", leds, 0);

    // Restart from WIN, then a wrong press at round 2 step 1.
    pulse_start();
    for (int r = 0; r < 2; r++) begin
      play_round(r);
      answer_round(r, -1, 4'd0, TMO - 1);
    end
    play_round(2);
    answer_round(2, 1, 4'b0010, TMO - 1);
    step();
    check("lose_hold", lost, 1);
    check("lose_hold_round", round, 2);

    // Timeout: exactly TMO silent cycles in IN_WAIT.
    pulse_start();
    play_round(0);
    for (int c = 0; c < TMO; c++) begin
      check("tmo_waiting", waiting_input, 1);
      check("tmo_not_lost", lost, 0);
      step();
    end
    check("tmo_lost", lost, 1);

    // Multi-hot press loses.
    pulse_start();
    play_round(0);
    answer_round(0, 0, 4'b0011, TMO - 1);

    // Button held through playback/IN_FETCH is not a press until re-pressed.
    pulse_start();
    buttons = 4'b0001;
    play_round(0);
    repeat (3) begin
      step();
      check("held_ignored", waiting_input, 1);
    end
    buttons = 4'd0;
    step();
    check("held_release", waiting_input, 1);
    answer_round(0, -1, 4'd0, TMO - 5);

    // Now on round 1 SHOW_FETCH: start must be ignored in SHOW_ON.
    step();
    check("ign_show", leds, rom[0]);
    start = 1'b1;
    step();
    start = 1'b0;
    check("ign_start_leds", leds, rom[0]);
    check("ign_start_round", round, 1);

    // Reset mid-playback.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("rst_show");
    repeat (3) step();
    check_all_zero("rst_show_idle");

    // Reset mid-input.
    pulse_start();
    play_round(0);
    repeat (3) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("rst_wait");
    repeat (2) step();
    check_all_zero("rst_wait_idle");

    // Clean restart after reset.
    pulse_start();
    play_round(0);
    answer_round(0, -1, 4'd0, TMO - 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
